mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 208 ++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus UART/cycle-counter IO window for a simple CPU.
// Latency: reads return on mem_din one cycle after the address; writes complete at the clock edge.
// Backpressure: no stall towards the CPU; io_buffer_full warns of a nearly full TX FIFO, and a push into a full FIFO with no pop is dropped.
//
// Ports:
//   clk, rst            - single clock, asynchronous active-high reset
//   mem_a/mem_dout/mem_wr/mem_din - CPU access: address, write data, write strobe, registered read data
//   io_buffer_full      - registered TX FIFO occupancy warning
//   uart_tx_valid/uart_tx_data/uart_tx_ready - TX FIFO head, valid/ready handshake
//   uart_rx_valid/uart_rx_data/uart_rx_pop   - RX byte source; pop is a same-cycle consume pulse
//   program_stop        - sticky flag set by a write to 0x30004
//
// Address map (mem_a[17:0] decoded, mem_a[17:16]==2'b11 selects IO):
//   0x30000 R: RX byte (0x00 if none)   W: push to TX FIFO (0x00 ignored)
//   0x30004 R: snapshot counter, byte 0 W: stop program, push 0x00, freeze counter
//   0x30005..0x30007 R: snapshot bytes 1..3
//   other IO offsets read 0x00, writes ignored
//
// Optional feature: define MEM_IO_RX_EN to enable the UART RX read path.
// Without it, 0x30000 reads as 0x00 and uart_rx_pop is held at 0.

module mem_io_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_pop,
    output logic        program_stop
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int CNT_W    = TX_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(TX_DEPTH - FULL_MARGIN);

    localparam logic [15:0] OFF_UART = 16'h0000;
    localparam logic [15:0] OFF_CYC0 = 16'h0004;
    localparam logic [15:0] OFF_CYC1 = 16'h0005;
    localparam logic [15:0] OFF_CYC2 = 16'h0006;
    localparam logic [15:0] OFF_CYC3 = 16'h0007;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                     is_io;
    logic [15:0]              io_off;
    logic [RAM_ADDR_BITS-1:0] ram_addr;

    assign is_io    = (mem_a[17:16] == 2'b11);
    assign io_off   = mem_a[15:0];
    assign ram_addr = mem_a[RAM_ADDR_BITS-1:0];

    // ------------------------------------------------------------------
    // Byte RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] ram [0:(1 << RAM_ADDR_BITS)-1];
    logic       ram_we;

    assign ram_we = mem_wr & ~is_io;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= mem_dout;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic       rx_hit;
    logic [7:0] rx_byte;

`ifdef MEM_IO_RX_EN
    assign rx_hit  = ~mem_wr & is_io & (io_off == OFF_UART) & uart_rx_valid;
    assign rx_byte = uart_rx_data;
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a[31:18];
`else
    assign rx_hit  = 1'b0;
    assign rx_byte = 8'h00;
    logic unused_rx_inputs;
    assign unused_rx_inputs = ^{mem_a[31:18], uart_rx_valid, uart_rx_data};
`endif

    // The pop must accompany the read cycle itself so back-to-back reads of
    // 0x30000 never return the same RX byte twice.
    assign uart_rx_pop = rx_hit & ~rst;

    // ------------------------------------------------------------------
    // Cycle counter and snapshot
    // ------------------------------------------------------------------
    logic [31:0] cyc_cnt;
    logic [31:0] snap;
    logic        snap_load;

    // ------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte   = ram[ram_addr];
        snap_load = 1'b0;
        if (is_io) begin
            rd_byte = 8'h00;
            case (io_off)
                OFF_UART: rd_byte = rx_hit ? rx_byte : 8'h00;
                OFF_CYC0: begin
                    // Byte 0 comes straight from the live counter, which is
                    // exactly what the snapshot captures on this same edge.
                    rd_byte   = cyc_cnt[7:0];
                    snap_load = ~mem_wr;
                end
                OFF_CYC1: rd_byte = snap[15:8];
                OFF_CYC2: rd_byte = snap[23:16];
                OFF_CYC3: rd_byte = snap[31:24];
                default:  rd_byte = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IO write decode
    // ------------------------------------------------------------------
    logic       io_wr;
    logic       stop_req;
    logic       tx_push;
    logic [7:0] tx_byte;

    assign io_wr    = mem_wr & is_io & ~program_stop;
    assign stop_req = io_wr & (io_off == OFF_CYC0);
    // The end-of-program marker 0x00 bypasses the zero-byte filter.
    assign tx_push  = stop_req | (io_wr & (io_off == OFF_UART) & (mem_dout != 8'h00));
    assign tx_byte  = stop_req ? 8'h00 : mem_dout;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]               tx_mem [0:TX_DEPTH-1];
    logic [TX_DEPTH_LOG2-1:0] wr_ptr;
    logic [TX_DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     tx_pop;
    logic                     tx_push_ok;

    assign uart_tx_valid = (count != '0);
    assign uart_tx_data  = tx_mem[rd_ptr];
    assign tx_pop        = uart_tx_valid & uart_tx_ready;
    // A simultaneous pop frees the slot, so a push at full still lands.
    assign tx_push_ok    = tx_push & ((count != DEPTH_CNT) | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push_ok) begin
            tx_mem[wr_ptr] <= tx_byte;
        end
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_din        <= 8'h00;
            cyc_cnt        <= 32'd0;
            snap           <= 32'd0;
            program_stop   <= 1'b0;
            io_buffer_full <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            if (!mem_wr) begin
                mem_din <= rd_byte;
            end
            if (snap_load) begin
                snap <= cyc_cnt;
            end
            // The counter stops on the very edge that sets program_stop.
            if (!program_stop && !stop_req) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            if (stop_req) begin
                program_stop <= 1'b1;
            end
            io_buffer_full <= (count >= FULL_THRESH);
            if (tx_push_ok) begin
                wr_ptr <= wr_ptr + TX_DEPTH_LOG2'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + TX_DEPTH_LOG2'(1);
            end
            count <= count + CNT_W'(tx_push_ok) - CNT_W'(tx_pop);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready = 1'b0;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h0;
    logic        uart_rx_pop;
    logic        program_stop;

`ifdef MEM_IO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_pop    (uart_rx_pop),
        .program_stop   (program_stop)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: RAM as a sparse map, TX FIFO as a queue.
    logic [7:0] m_ram [int];
    logic [7:0] m_q [$];
    logic [7:0] m_din;
    bit         m_din_known;
    bit         m_full;
    bit         m_stop;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        rdy;
        logic [7:0]  e_din;
        logic        e_vld;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction

    task automatic check_model();
        if (m_din_known) chk("mem_din", 32'(mem_din), 32'(m_din));
        chk("tx_valid", 32'(uart_tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tx_data", 32'(uart_tx_data), 32'(m_q[0]));
        chk("io_full", 32'(io_buffer_full), 32'(m_full));
        chk("stop", 32'(program_stop), 32'(m_stop));
        chk("rx_pop", 32'(uart_rx_pop),
            32'(RX_EN && !mem_wr && is_io(mem_a) && mem_a[15:0] == 16'h0 && uart_rx_valid));
    endtask

    task automatic model_update();
        int         sz;
        bit         pop;
        bit         push;
        logic [7:0] pd;
        int         key;
        sz   = m_q.size();
        pop  = (sz != 0) && uart_tx_ready;
        push = 1'b0;
        pd   = 8'h00;
        key  = int'(mem_a[16:0]);
        if (mem_wr) begin
            if (is_io(mem_a)) begin
                if (!m_stop && mem_a[15:0] == 16'h0 && mem_dout != 8'h00) begin
                    push = 1'b1; pd = mem_dout;
                end else if (!m_stop && mem_a[15:0] == 16'h4) begin
                    push = 1'b1; pd = 8'h00; m_stop = 1'b1;
                end
            end else begin
                m_ram[key] = mem_dout;
            end
        end else begin
            if (is_io(mem_a)) begin
                m_din_known = 1'b1;
                if (mem_a[15:0] == 16'h0)
                    m_din = (RX_EN && uart_rx_valid) ? uart_rx_data : 8'h00;
                else if (mem_a[15:0] >= 16'h4 && mem_a[15:0] <= 16'h7)
                    m_din_known = 1'b0;
                else
                    m_din = 8'h00;
            end else if (m_ram.exists(key)) begin
                m_din = m_ram[key]; m_din_known = 1'b1;
            end else begin
                m_din_known = 1'b0;
            end
        end
        m_full = (sz >= 14);
        if (pop) void'(m_q.pop_front());
        if (push && (sz < 16 || pop)) m_q.push_back(pd);
    endtask

    // One bus cycle: drive just after the edge, check mid-cycle, update model at the edge.
    task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic rdy);
        mem_wr = wr; mem_a = a; mem_dout = d; uart_tx_ready = rdy;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0003_001C, 8'h00, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_wr = 1'b0; mem_a = 32'h0003_001C; mem_dout = 8'h00;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        m_q.delete(); m_din = 8'h00; m_din_known = 1'b1; m_full = 1'b0; m_stop = 1'b0;
        #1;
        chk("rst_din", 32'(mem_din), 32'h0);
        chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("rst_full", 32'(io_buffer_full), 32'h0);
        chk("rst_stop", 32'(program_stop), 32'h0);
        chk("rst_rx_pop", 32'(uart_rx_pop), 32'h0);
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic read_snap(output logic [31:0] s);
        step(1'b0, 32'h0003_0004, 8'h00, 1'b0); s[7:0]   = mem_din;
        step(1'b0, 32'h0003_0005, 8'h00, 1'b0); s[15:8]  = mem_din;
        step(1'b0, 32'h0003_0006, 8'h00, 1'b0); s[23:16] = mem_din;
        step(1'b0, 32'h0003_0007, 8'h00, 1'b0); s[31:24] = mem_din;
    endtask

    initial begin
        logic [7:0]  got [$];
        logic [31:0] s1, s2, s3, s4;

        vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 32'h0003_0000, 8'h41, 1'b0, 8'hA5, 1'b1, 8'h41};
        vecs[3]  = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'hA5, 1'b1, 8'h41};
        vecs[4]  = '{1'b1, 32'h0003_0000, 8'h42, 1'b0, 8'hA5, 1'b1, 8'h41};
        vecs[5]  = '{1'b0, 32'h0002_0010, 8'h00, 1'b1, 8'hA5, 1'b1, 8'h42};
        vecs[6]  = '{1'b0, 32'h0003_001C, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 32'h0001_0010, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 32'hFFF0_0010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 32'h0001_0010, 8'h00, 1'b0, 8'h3C, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 32'h0003_0001, 8'h77, 1'b0, 8'h3C, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 32'h0003_0002, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};

        #1;
        do_reset();

        // Directed vectors: RAM write/read, aliasing, TX pushes with zero filter, drain.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d_din", i), 32'(mem_din), 32'(vecs[i].e_din));
            chk($sformatf("vec%0d_valid", i), 32'(uart_tx_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) chk($sformatf("vec%0d_data", i), 32'(uart_tx_data), 32'(vecs[i].e_dat));
        end

        // FIFO fill: full flag lag, drop at full, push+pop at full.
        for (int i = 1; i <= 14; i++) step(1'b1, 32'h0003_0000, 8'(i), 1'b0);
        chk("full_lag", 32'(io_buffer_full), 32'h0);
        idle(1'b0);
        chk("full_set", 32'(io_buffer_full), 32'h1);
        step(1'b1, 32'h0003_0000, 8'd15, 1'b0);
        step(1'b1, 32'h0003_0000, 8'd16, 1'b0);
        step(1'b1, 32'h0003_0000, 8'd17, 1'b0);
        step(1'b1, 32'h0003_0000, 8'd18, 1'b1);
        for (int k = 0; k < 40 && uart_tx_valid; k++) begin
            got.push_back(uart_tx_data);
            idle(1'b1);
        end
        chk("drain_len", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            chk("drain_first", 32'(got[0]), 32'd2);
            chk("drain_15th", 32'(got[14]), 32'd16);
            chk("drain_last", 32'(got[15]), 32'd18);
        end
        idle(1'b0);
        chk("full_clear", 32'(io_buffer_full), 32'h0);

        // Reset mid-operation drops pending TX bytes and in-flight read; RAM survives.
        step(1'b1, 32'h0003_0000, 8'h11, 1'b0);
        step(1'b1, 32'h0003_0000, 8'h22, 1'b0);
        step(1'b0, 32'h0000_0010, 8'h00, 1'b0);
        do_reset();
        step(1'b0, 32'h0000_0010, 8'h00, 1'b0);
        chk("ram_kept", 32'(mem_din), 32'hA5);

        // Cycle counter snapshot.
        do_reset();
        repeat (100) idle(1'b0);
        read_snap(s1);
        chk("snap_ge100", 32'(s1 >= 32'd100), 32'h1);
        chk("snap_sane", 32'(s1 < 32'd200), 32'h1);
        repeat (10) idle(1'b0);
        read_snap(s2);
        chk("snap_delta", s2 - s1, 32'd14);

        // Program stop: marker byte, frozen counter, later IO writes ignored.
        step(1'b1, 32'h0003_0004, 8'h99, 1'b0);
        chk("stop_set", 32'(program_stop), 32'h1);
        chk("stop_marker_vld", 32'(uart_tx_valid), 32'h1);
        chk("stop_marker", 32'(uart_tx_data), 32'h00);
        read_snap(s3);
        repeat (5) idle(1'b0);
        read_snap(s4);
        chk("cnt_frozen", s4, s3);
        step(1'b1, 32'h0003_0000, 8'h55, 1'b0);
        idle(1'b1);
        chk("no_push_after_stop", 32'(uart_tx_valid), 32'h0);
        step(1'b1, 32'h0000_0040, 8'h77, 1'b0);
        step(1'b0, 32'h0000_0040, 8'h00, 1'b0);
        chk("ram_after_stop", 32'(mem_din), 32'h77);

        // RX path (model checks the pop pulse each cycle).
        do_reset();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
        step(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        chk("rx_read", 32'(mem_din), RX_EN ? 32'h7E : 32'h00);
        step(1'b0, 32'h0003_0001, 8'h00, 1'b0);
        chk("rx_other", 32'(mem_din), 32'h00);
        step(1'b1, 32'h0003_0000, 8'h00, 1'b0);
        uart_rx_valid = 1'b0;
        step(1'b0, 32'h0003_0000, 8'h00, 1'b0);
        chk("rx_empty", 32'(mem_din), 32'h00);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int          r;
            logic [31:0] a;
            logic [7:0]  d;
            logic        rdy;
            r   = int'($urandom_range(0, 199));
            d   = 8'($urandom);
            rdy = ($urandom_range(0, 3) == 0);
            uart_rx_valid = 1'($urandom);
            uart_rx_data  = 8'($urandom);
            a = 32'h100 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = a | 32'h0002_0000;
            if (r < 50)       step(1'b1, a, d, rdy);
            else if (r < 100) step(1'b0, a, 8'h00, rdy);
            else if (r < 150) step(1'b1, 32'h0003_0000, ($urandom_range(0, 3) == 0) ? 8'h00 : d, rdy);
            else if (r < 165) step(1'b0, 32'h0003_0000, 8'h00, rdy);
            else if (r < 180) step(1'($urandom), 32'h0003_0000 | 32'($urandom_range(5, 15)), d, rdy);
            else if (r < 198) step(1'b0, 32'h0003_0004 + 32'($urandom_range(0, 3)), 8'h00, rdy);
            else              step(1'b1, 32'h0003_0004, d, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
